braille_matrix_sequencer: RTL and testbench
===========================================

Name: braille_matrix_sequencer

Overview:
- Parametrised successor to the fixed 5x2 braille actuator core: drives a ROWS x COLS dot matrix through per-line H-bridge pairs.
- Frame data arrives on an SPI slave (daisy-chainable) into a shift register, is committed by latch_data_n, and is scanned dot-by-dot on trigger_in_n.
- Each dot gets a timed set/clear pulse followed by dead time; trigger_out_n chains to the next cell.
- Sits under the caravel wrapper in place of the fixed-size core.

Parameters:
- ROWS, 5, number of row lines.
- COLS, 2, number of column lines.
- CNT_W, 16, width of the pulse/dead-time counter.
- PULSE_CYCLES, 1000, clock cycles a dot is actively driven (1..2^CNT_W-1).
- DEAD_CYCLES, 100, clock cycles all bridges are off between dots (1..2^CNT_W-1).
- TRIG_OUT_CYCLES, 4, low width of trigger_out_n.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- enable_n  in  1  active-low global enable, async input
- trigger_in_n  in  1  falling edge starts scan, async input
- latch_data_n  in  1  falling edge commits shift register to active frame, async input
- sclk  in  1  SPI clock, mode 0, async input
- mosi  in  1  SPI data in, MSB first
- ss_n  in  1  SPI select, active-low
- miso  out  1  SPI data out (daisy chain)
- rows_hbrige  out  2*ROWS  [2r]=A leg, [2r+1]=B leg of row r
- cols_hbrige  out  2*COLS  [2c]=A leg, [2c+1]=B leg of col c
- trigger_out_n  out  1  active-low scan-complete pulse
- busy  out  1  high while a scan is in progress

Behaviour:
- Reset: all hbrige outputs 0, miso 0, trigger_out_n 1, busy 0, shift/active frame 0, state IDLE.
- All async inputs pass through 2-FF synchronisers; edges are detected on the synchronised copies.
- N = ROWS*COLS. Bit index i = c*ROWS + r (row fastest).
- SPI: while ss_n is low, each synchronised sclk rising edge shifts mosi into shift[0]; miso = shift[N-1] while ss_n is low, else 0. More than N bits pass through to miso. ss_n high freezes the register.
- Latch: a latch_data_n falling edge in IDLE copies shift -> active on the next cycle. In any other state it sets latch_pending, which is applied on the IDLE entry cycle.
- FSM states: IDLE, PULSE, DEAD, DONE.
- IDLE -> PULSE on a trigger_in_n falling edge while enable_n is low; idx=0, cnt=0. The first PULSE output appears 3 clocks after the trigger_in_n fall.
- PULSE: drive dot idx for PULSE_CYCLES cycles, then go to DEAD.
  - Set (active bit 1): row A=1, col B=1.
  - Clear (active bit 0): row B=1, col A=1.
  - All other legs are 0.
- DEAD: all legs 0 for DEAD_CYCLES cycles.
  - If idx == N-1, go to DONE.
  - Otherwise idx+1 -> PULSE.
- DONE: trigger_out_n low for TRIG_OUT_CYCLES cycles, then IDLE.
- busy is 1 in PULSE, DEAD and DONE.
- Full scan length = N*(PULSE_CYCLES+DEAD_CYCLES) + TRIG_OUT_CYCLES cycles.
- Triggers while busy are ignored and are not queued.
- Synchronised enable_n high in PULSE or DEAD: next cycle all legs 0, go to IDLE, no trigger_out_n pulse, a pending latch is applied.
- A and B of the same bridge are never 1 simultaneously, in any state.
- Reset asserted mid-scan returns everything to reset values immediately (asynchronous).
- The active frame is only written in IDLE, so it is stable during a scan.

Optional Feature:
- Macro: SKIP_UNCHANGED_EN.
- Defined:
  - A driven[N] register (reset 0) holds the last pulsed state of each dot.
  - In PULSE, if active[idx] == driven[idx], the dot is skipped in 1 cycle: no leg asserted, no DEAD, idx advances (or goes to DONE if last).
  - On completion of a dot's PULSE, driven[idx] <= active[idx].
  - An enable abort leaves driven holding only completed dots.
- Undefined: every dot is pulsed every scan and the driven register is absent.

Test Plan:
- Reset release with all inputs idle -> all hbrige 0, trigger_out_n 1, busy 0, miso 0.
- PULSE_CYCLES=4, DEAD_CYCLES=2, TRIG_OUT_CYCLES=4. SPI load 10'b10_0000_0001, latch, trigger:
  - dot0: rows_hbrige=10'h001 and cols_hbrige=4'b0010 for 4 cycles, then 2 cycles all 0.
  - dots 1..8: clear pattern.
  - dot9: rows_hbrige=10'h100, cols_hbrige=4'b1000.
  - busy is high for 64 cycles; trigger_out_n is low for exactly cycles 61-64.
- SPI shift of 20 bits, pattern X then Y -> miso reproduces X delayed by 10 sclk edges; active frame = Y after latch.
- Latch during scan with new data -> the current scan still uses the old frame; the new frame is active in IDLE; the following scan shows the new pattern.
- enable_n raised at cycle 15 of a scan -> legs 0 within 3 clocks, busy 0, no trigger_out_n pulse.
- A second trigger at cycle 5 of a scan is ignored.
- SKIP_UNCHANGED_EN, same frame scanned twice -> second scan asserts no legs, busy high for N+TRIG_OUT_CYCLES=14 cycles.
- Every scenario: assertion that A&B of any bridge is never 1.

Source files
------------

// File: rtl/braille_matrix_sequencer.sv
// braille_matrix_sequencer
// ROWS x COLS braille dot-matrix driver. An SPI slave (daisy-chainable) fills a
// shift register. A latch_data_n falling edge commits the shift register to the
// active frame. A trigger_in_n falling edge scans every dot once. Each dot gets a
// set or clear pulse through the row and column H-bridges, followed by dead time.
// trigger_out_n pulses low at the end of the scan to start the next cell.
// Optional build macro: SKIP_UNCHANGED_EN. When it is defined, the design skips
// any dot whose last driven state already matches the active frame.
module braille_matrix_sequencer #(
    parameter int ROWS            = 5,
    parameter int COLS            = 2,
    parameter int CNT_W           = 16,
    parameter int PULSE_CYCLES    = 1000,
    parameter int DEAD_CYCLES     = 100,
    parameter int TRIG_OUT_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_n,
    input  logic                trigger_in_n,
    input  logic                latch_data_n,
    input  logic                sclk,
    input  logic                mosi,
    input  logic                ss_n,
    output logic                miso,
    output logic [2*ROWS-1:0]   rows_hbrige,
    output logic [2*COLS-1:0]   cols_hbrige,
    output logic                trigger_out_n,
    output logic                busy
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TRIG_OUT_CYCLES - 1);

    // Synchroniser bit order: {ss_n, mosi, sclk, latch_data_n, trigger_in_n, enable_n}.
    // Each flop resets to the idle level of its input, so reset release creates no edge.
    localparam logic [5:0] SYNC_RST = 6'b100111;
    // Previous-value bit order: {sclk, latch_data_n, trigger_in_n}.
    localparam logic [2:0] PREV_RST = 3'b011;

    typedef enum logic [1:0] {IDLE, PULSE, DEAD, DONE} state_t;

    logic [5:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]       prev_q, prev_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [N-1:0]     active_q, active_d;
    logic             pending_q, pending_d;

    logic en_n_s, trig_s, latch_s, sclk_s, mosi_s, ss_n_s;
    logic trig_fall, latch_fall, sclk_rise;
    logic last_dot, dot_bit, skip_dot;

    assign en_n_s     = sync2_q[0];
    assign trig_s     = sync2_q[1];
    assign latch_s    = sync2_q[2];
    assign sclk_s     = sync2_q[3];
    assign mosi_s     = sync2_q[4];
    assign ss_n_s     = sync2_q[5];
    assign trig_fall  = prev_q[0] & ~trig_s;
    assign latch_fall = prev_q[1] & ~latch_s;
    assign sclk_rise  = ~prev_q[2] & sclk_s;
    assign last_dot   = (idx_q == IDX_W'(N - 1));
    assign dot_bit    = active_q[idx_q];

`ifdef SKIP_UNCHANGED_EN
    logic [N-1:0] driven_q, driven_d;

    assign skip_dot = (active_q[idx_q] == driven_q[idx_q]);

    // Record the new state of a dot only after its pulse has run to completion.
    always_comb begin
        driven_d = driven_q;
        if (state_q == PULSE && !en_n_s && !skip_dot && cnt_q == P_LAST)
            driven_d[idx_q] = active_q[idx_q];
    end

    // Register that holds the last state driven onto each dot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) driven_q <= '0;
        else       driven_q <= driven_d;
    end
`else
    assign skip_dot = 1'b0;
`endif

    // Two-stage synchronisers. prev_q holds the synchronised level from the
    // previous cycle so that edges can be detected.
    always_comb begin
        sync1_d = {ss_n, mosi, sclk, latch_data_n, trigger_in_n, enable_n};
        sync2_d = sync1_q;
        prev_d  = sync2_q[3:1];
    end

    // Synchroniser and edge-detect registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
            prev_q  <= PREV_RST;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // State register, counters and frame storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // Next state. An enable abort has priority over normal progress in PULSE and DEAD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (trig_fall && !en_n_s) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            PULSE: begin
                if (en_n_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (skip_dot) begin
                    cnt_d = '0;
                    if (last_dot) state_d = DONE;
                    else          idx_d   = idx_q + 1'b1;
                end else if (cnt_q == P_LAST) begin
                    state_d = DEAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEAD: begin
                if (en_n_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == D_LAST) begin
                    cnt_d = '0;
                    if (last_dot) begin
                        state_d = DONE;
                    end else begin
                        state_d = PULSE;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == T_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // SPI shift register and frame latch. The active frame changes only in IDLE.
    // A latch seen during a scan is deferred until the first IDLE cycle.
    always_comb begin
        shift_d   = shift_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (!ss_n_s && sclk_rise)
            shift_d = {shift_q[N-2:0], mosi_s};
        if (state_q == IDLE) begin
            if (latch_fall || pending_q) begin
                active_d  = shift_q;
                pending_d = 1'b0;
            end
        end else if (latch_fall) begin
            pending_d = 1'b1;
        end
    end

    // Outputs. Exactly one row leg and one column leg are driven, and only during
    // an active, non-skipped PULSE. This keeps A and B of a bridge exclusive.
    always_comb begin
        rows_hbrige = '0;
        cols_hbrige = '0;
        if (state_q == PULSE && !skip_dot) begin
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (idx_q == IDX_W'(c * ROWS + r)) begin
                        rows_hbrige[2*r]   = dot_bit;
                        rows_hbrige[2*r+1] = ~dot_bit;
                        cols_hbrige[2*c]   = ~dot_bit;
                        cols_hbrige[2*c+1] = dot_bit;
                    end
                end
            end
        end
        trigger_out_n = (state_q != DONE);
        busy          = (state_q != IDLE);
        miso          = ~ss_n_s & shift_q[N-1];
    end

endmodule

// File: tb/tb_braille_matrix_sequencer.sv
// tb_braille_matrix_sequencer
// Randomised frames checked cycle by cycle against a reference trace. The trace
// is built from the dot rules: for each dot, a pulse followed by dead time (or one
// skip cycle when SKIP_UNCHANGED_EN is defined), then the trigger_out_n tail.
module tb_braille_matrix_sequencer;

    localparam int R = 5;
    localparam int C = 2;
    localparam int N = R * C;
    localparam int P = 4;
    localparam int D = 2;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable_n = 1'b0, trigger_in_n = 1'b1, latch_data_n = 1'b1;
    logic sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
    logic miso, trigger_out_n, busy;
    logic [2*R-1:0] rows_hbrige;
    logic [2*C-1:0] cols_hbrige;

    typedef struct packed {
        logic [2*R-1:0] rows;
        logic [2*C-1:0] cols;
        logic           trig_n;
        logic           busy;
    } obs_t;

    obs_t         exp_q[$];
    int           done_q[$];
    bit           hist[$];
    logic [N-1:0] act_m, drv_m;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           viol = 0;

    braille_matrix_sequencer #(
        .ROWS(R), .COLS(C), .CNT_W(16),
        .PULSE_CYCLES(P), .DEAD_CYCLES(D), .TRIG_OUT_CYCLES(T)
    ) dut (
        .clock(clk), .reset(rst), .enable_n(enable_n), .trigger_in_n(trigger_in_n),
        .latch_data_n(latch_data_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .rows_hbrige(rows_hbrige), .cols_hbrige(cols_hbrige),
        .trigger_out_n(trigger_out_n), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bridge exclusivity monitor
    always @(negedge clk) begin
        if (!rst) begin
            for (int r = 0; r < R; r++)
                if (rows_hbrige[2*r] && rows_hbrige[2*r+1]) viol++;
            for (int c = 0; c < C; c++)
                if (cols_hbrige[2*c] && cols_hbrige[2*c+1]) viol++;
        end
    end

    function automatic obs_t idle_obs();
        obs_t o;
        o.rows = '0; o.cols = '0; o.trig_n = 1'b1; o.busy = 1'b0;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.rows = rows_hbrige; o.cols = cols_hbrige;
        o.trig_n = trigger_out_n; o.busy = busy;
        return o;
    endfunction

    // The last N bits shifted in, with bit 0 being the most recent.
    function automatic logic [N-1:0] shift_model();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = hist[hist.size() - 1 - i];
        return v;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < N; i++) hist.push_back(1'b0);
        act_m = '0;
        drv_m = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_frame(output logic [N-1:0] f);
        logic [31:0] rnd;
        rnd = $urandom();
        f = rnd[N-1:0];
    endtask

    // Builds the expected per-cycle trace of a full scan of the given frame.
    task automatic build_trace(input logic [N-1:0] frame);
        obs_t o;
        bit   skip;
        exp_q.delete();
        done_q.delete();
        for (int i = 0; i < N; i++) begin
            skip = 1'b0;
`ifdef SKIP_UNCHANGED_EN
            skip = (frame[i] == drv_m[i]);
`endif
            if (skip) begin
                exp_q.push_back(obs_t'{rows: '0, cols: '0, trig_n: 1'b1, busy: 1'b1});
                done_q.push_back(-1);
            end else begin
                o = obs_t'{rows: '0, cols: '0, trig_n: 1'b1, busy: 1'b1};
                o.rows[2*(i % R) + (frame[i] ? 0 : 1)] = 1'b1;
                o.cols[2*(i / R) + (frame[i] ? 1 : 0)] = 1'b1;
                for (int k = 0; k < P; k++) begin
                    exp_q.push_back(o);
                    done_q.push_back(k == P - 1 ? i : -1);
                end
                for (int k = 0; k < D; k++) begin
                    exp_q.push_back(obs_t'{rows: '0, cols: '0, trig_n: 1'b1, busy: 1'b1});
                    done_q.push_back(-1);
                end
            end
        end
        for (int k = 0; k < T; k++) begin
            exp_q.push_back(obs_t'{rows: '0, cols: '0, trig_n: 1'b0, busy: 1'b1});
            done_q.push_back(-1);
        end
    endtask

    // Triggers one scan and compares every cycle against the trace.
    // abort_at > 0 raises enable_n during that scan cycle.
    // retrig_at > 0 sends a second trigger during that scan cycle.
    task automatic run_scan(input string name, input logic [N-1:0] frame,
                            input int abort_at, input int retrig_at);
        obs_t got, exp;
        int   len, stop, lim, k;
        build_trace(frame);
        len  = exp_q.size();
        stop = (abort_at > 0) ? abort_at + 2 : len;
        @(posedge clk); #1;
        trigger_in_n = 1'b0;
        for (int p = 1; p <= len + 8; p++) begin
            tick(1);
            k = p - 2;
            if (p == 3) trigger_in_n = 1'b1;
            if (abort_at > 0 && k == abort_at) enable_n = 1'b1;
            if (retrig_at > 0 && k == retrig_at) trigger_in_n = 1'b0;
            if (retrig_at > 0 && k == retrig_at + 3) trigger_in_n = 1'b1;
            @(negedge clk);
            if (k >= 1) begin
                exp = (k <= stop) ? exp_q[k-1] : idle_obs();
                got = observe();
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: got rows=%h cols=%h trig_n=%b busy=%b, expected rows=%h cols=%h trig_n=%b busy=%b",
                             name, k, got.rows, got.cols, got.trig_n, got.busy,
                             exp.rows, exp.cols, exp.trig_n, exp.busy);
                end
            end
        end
        lim = (abort_at > 0) ? abort_at + 1 : len;
        for (int j = 0; j < lim; j++)
            if (done_q[j] >= 0) drv_m[done_q[j]] = frame[done_q[j]];
        enable_n = 1'b0;
        tick(3);
    endtask

    task automatic spi_load(input logic [N-1:0] bits);
        ss_n = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            mosi = bits[i];
            sclk = 1'b0;
            tick(2);
            sclk = 1'b1;
            hist.push_back(bits[i]);
            tick(2);
        end
        sclk = 1'b0;
        tick(2);
        ss_n = 1'b1;
        tick(2);
    endtask

    task automatic latch_pulse();
        latch_data_n = 1'b0;
        tick(3);
        latch_data_n = 1'b1;
        tick(3);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({observe(), miso} !== {idle_obs(), 1'b0}) begin
            n_bad++;
            $display("FAIL reset_held: got %h, expected %h", {observe(), miso}, {idle_obs(), 1'b0});
        end
        tick(2);
        rst = 1'b0;
        tick(4);
        @(negedge clk);
        n_cmp++;
        if ({observe(), miso} !== {idle_obs(), 1'b0}) begin
            n_bad++;
            $display("FAIL reset_release: got %h, expected %h", {observe(), miso}, {idle_obs(), 1'b0});
        end
    endtask

    task automatic test_directed_scan();
        logic [N-1:0] f;
        f = 10'b10_0000_0001;
        spi_load(f);
        latch_pulse();
        act_m = shift_model();
        run_scan("directed_scan", act_m, 0, 0);
    endtask

    task automatic test_spi_passthrough();
        logic [N-1:0] x, y;
        logic [2*N-1:0] both;
        rand_frame(x);
        rand_frame(y);
        both = {x, y};
        ss_n = 1'b0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            mosi = both[i];
            sclk = 1'b0;
            tick(2);
            n_cmp++;
            if (miso !== hist[hist.size() - N]) begin
                n_bad++;
                $display("FAIL spi_miso bit %0d: got %b, expected %b", 2 * N - 1 - i, miso, hist[hist.size() - N]);
            end
            sclk = 1'b1;
            hist.push_back(both[i]);
            tick(2);
        end
        sclk = 1'b0;
        tick(2);
        ss_n = 1'b1;
        tick(3);
        n_cmp++;
        if (miso !== 1'b0) begin
            n_bad++;
            $display("FAIL spi_miso_deselected: got %b, expected 0", miso);
        end
        latch_pulse();
        act_m = shift_model();
        run_scan("spi_frame_y", act_m, 0, 0);
    endtask

    task automatic test_random_scans();
        logic [N-1:0] f;
        for (int n = 0; n < 3; n++) begin
            rand_frame(f);
            spi_load(f);
            latch_pulse();
            act_m = shift_model();
            run_scan($sformatf("random_scan%0d", n), act_m, 0, 0);
        end
    endtask

    task automatic test_latch_during_scan();
        logic [N-1:0] b, old;
        rand_frame(b);
        b = b ^ act_m ^ 10'h3ff;
        old = act_m;
        fork
            run_scan("latch_mid_scan_old", old, 0, 0);
            begin
                tick(8);
                spi_load(b);
                latch_pulse();
            end
        join
        act_m = shift_model();
        run_scan("latch_mid_scan_new", act_m, 0, 0);
    endtask

    task automatic test_abort();
        logic [N-1:0] f;
        rand_frame(f);
        spi_load(f);
        latch_pulse();
        act_m = shift_model();
        run_scan("enable_abort", act_m, 15, 0);
        run_scan("after_abort", act_m, 0, 0);
    endtask

    task automatic test_retrigger();
        run_scan("retrigger_ignored", act_m, 0, 5);
    endtask

`ifdef SKIP_UNCHANGED_EN
    task automatic test_skip();
        logic [N-1:0] f;
        int busy_cnt;
        rand_frame(f);
        spi_load(f);
        latch_pulse();
        act_m = shift_model();
        run_scan("skip_first", act_m, 0, 0);
        run_scan("skip_second", act_m, 0, 0);
        busy_cnt = 0;
        foreach (exp_q[j]) if (exp_q[j].busy) busy_cnt++;
        n_cmp++;
        if (busy_cnt != N + T) begin
            n_bad++;
            $display("FAIL skip_scan_length: got %0d, expected %0d", busy_cnt, N + T);
        end
    endtask
`endif

    task automatic test_reset_mid_scan();
        @(posedge clk); #1;
        trigger_in_n = 1'b0;
        tick(3);
        trigger_in_n = 1'b1;
        tick(10);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({observe(), miso} !== {idle_obs(), 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid_scan: got %h, expected %h", {observe(), miso}, {idle_obs(), 1'b0});
        end
        model_reset();
        tick(2);
        rst = 1'b0;
        tick(3);
        run_scan("post_reset_scan", act_m, 0, 0);
    endtask

    task automatic test_bridge_exclusive();
        n_cmp++;
        if (viol !== 0) begin
            n_bad++;
            $display("FAIL bridge_exclusive: got %0d violations, expected 0", viol);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_directed_scan();
        test_spi_passthrough();
        test_random_scans();
        test_latch_during_scan();
        test_abort();
        test_retrigger();
`ifdef SKIP_UNCHANGED_EN
        test_skip();
`endif
        test_reset_mid_scan();
        test_bridge_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
